match_burst_fsm: RTL and testbench
==================================

// Module: match_burst_fsm
// PURPOSE
//  Parametrised successor to the single-channel match-count/hit-burst FSM.
//  During a valid window it counts beats whose seq equals a reference num.
//  When the window closes it asserts hit for exactly that many cycles.
//  Adds over the previous generation:
//   - parametrised data and count widths
//   - saturating count with a sticky overflow flag
//   - ready back-pressure, reference latched at window start
//   - optional compare mask
//  Sits between a sequence source and a downstream pulse consumer.
// PARAMETERS
//  DATA_W  4  width of num/seq
//  CNT_W   4  width of the match counter; max count = 2**CNT_W-1
// PORTS
//  clock    in   1       single clock, rising edge
//  reset    in   1       one clock; reset is synchronous and active-low (reset==0 resets)
//  valid    in   1       window qualifier; seq sampled when valid&ready
//  num      in   DATA_W  reference value; latched on first beat of a window
//  seq      in   DATA_W  sample compared against the latched reference
//  ready    out  1       1 when a valid beat will be accepted (state!=HIT)
//  hit      out  1       registered; high for cnt cycles after window close
//  cnt      out  CNT_W   current match count (registered)
//  sat      out  1       sticky: count saturated in current window
//  state    out  2       IDLE=2'b00, COUNT=2'b01, HIT=2'b10
// BEHAVIOUR
//  Reset (rising edge with reset==0), regardless of current state:
//   - state=IDLE, cnt=0, hit=0, sat=0, num_q=0; ready=1
//   - any burst in progress is aborted immediately
//  match = (seq==num_q); on the first beat, compare against num, not num_q.
//  IDLE, valid=1:
//   - num_q<=num, cnt<=match?1:0, state<=COUNT, sat<=0
//  IDLE, valid=0: hold.
//  COUNT, valid=1:
//   - if match: cnt<=cnt+1
//   - if cnt==max: cnt holds, sat<=1 (no wrap)
//  COUNT, valid=0 (window close):
//   - cnt>0: state<=HIT, hit<=1
//   - cnt==0: state<=IDLE, hit stays 0
//  HIT: each edge cnt<=cnt-1.
//   - when cnt==1: state<=IDLE, hit<=0
//   - hit is high for exactly the closing cnt value in cycles
//   - first hit cycle is the cycle after the first valid=0 edge
//  HIT ignores valid; ready=0; dropped beats are not counted or queued.
//  Back-to-back windows: valid may rise in the first IDLE cycle after HIT
//   ends (zero-bubble restart).
//  Window of length 1:
//   - one COUNT beat; with a match, hit is high for 1 cycle
//  cnt, hit, sat and state are flops; ready is combinational from state.
//  sat clears only on a new window start or reset.
//  Illegal state encoding 2'b11: next state IDLE with outputs cleared.
// CONFIGURATION
//  MATCH_BURST_MASK_EN defined:
//   - adds port "mask in DATA_W"
//   - mask is latched with num into mask_q
//   - match = ((seq^num_q)&mask_q)==0; mask=0 makes every beat match
//  Undefined: no mask port; full-width equality compare.
// TESTING
//  1. reset low 1 cycle, then 10 beats seq=~num
//     -> cnt=0, hit never asserted, state back to IDLE one cycle after valid falls
//  2. 10 beats seq==num (num=5)
//     -> cnt=10
//     -> hit high exactly 10 cycles, starting the cycle after valid falls
//     -> ready=0 throughout the burst
//  3. Length-1 window, match -> hit high 1 cycle.
//     Length-1 window, no match -> no hit.
//  4. CNT_W=4, 20 matching beats -> cnt stops at 15, sat=1, hit high 15 cycles.
//  5. valid held high through HIT -> beats ignored.
//     New window starts the first cycle ready=1 and counts correctly.
//  6. reset low mid-burst (cnt=6) -> next cycle hit=0, cnt=0, state=IDLE.
//     With MATCH_BURST_MASK_EN, mask=4'b0011, num=5, seq=4'b1101
//     -> counted as a match.

Source files
------------

// File: rtl/match_burst_fsm.sv
// ---------------------------------------------------------------------------
// match_burst_fsm
//
// Purpose
//   Counts the beats of a valid window whose sample equals a reference value.
//   When the window closes, emits a hit burst that lasts exactly as many cycles
//   as the number of matches counted. The count saturates at 2**CNT_W-1 and
//   raises a sticky overflow flag. The reference (and the optional compare
//   mask) is captured on the first beat of each window.
//
// Parameters
//   DATA_W  width of num/seq (and mask)
//   CNT_W   width of the match counter
//
// Ports
//   clock  in   1       single clock, rising edge
//   reset  in   1       synchronous, active-low (reset==0 resets)
//   valid  in   1       window qualifier; seq sampled when valid&ready
//   num    in   DATA_W  reference value, latched on first beat of a window
//   seq    in   DATA_W  sample compared against the latched reference
//   mask   in   DATA_W  compare mask (only with MATCH_BURST_MASK_EN)
//   ready  out  1       high whenever a beat would be accepted (state!=HIT)
//   hit    out  1       registered burst output
//   cnt    out  CNT_W   registered match count
//   sat    out  1       sticky: count saturated in the current window
//   state  out  2       IDLE=2'b00, COUNT=2'b01, HIT=2'b10
//
// Build option
//   MATCH_BURST_MASK_EN  when defined, adds the mask port; a beat matches when
//                        ((seq ^ num_q) & mask_q) == 0. Undefined: full-width
//                        equality compare and no mask port.
// ---------------------------------------------------------------------------
module match_burst_fsm #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] num,
  input  logic [DATA_W-1:0] seq,
`ifdef MATCH_BURST_MASK_EN
  input  logic [DATA_W-1:0] mask,
`endif
  output logic              ready,
  output logic              hit,
  output logic [CNT_W-1:0]  cnt,
  output logic              sat,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_HIT   = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DATA_W-1:0] FULL_MASK = '1;

  // Masked compare: bits where the mask is 0 never cause a mismatch.
  function automatic logic beat_match(input logic [DATA_W-1:0] s,
                                      input logic [DATA_W-1:0] r,
                                      input logic [DATA_W-1:0] m);
    return ((s ^ r) & m) == '0;
  endfunction

  // Saturating increment. Returns {overflow, next_count}; at the ceiling the
  // count holds and overflow is flagged instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                             input logic             en);
    if (!en)
      return {1'b0, c};
    else if (c == CNT_MAX)
      return {1'b1, c};
    else
      return {1'b0, c + CNT_ONE};
  endfunction

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                hit_q, hit_nxt;
  logic                sat_q, sat_nxt;
  logic [DATA_W-1:0]   num_q, num_nxt;
  logic [DATA_W-1:0]   cmp_mask_first;
  logic [DATA_W-1:0]   cmp_mask;
  logic                match_first;
  logic                match_q;
  logic [CNT_W:0]      inc_res;

`ifdef MATCH_BURST_MASK_EN
  logic [DATA_W-1:0]   mask_q, mask_nxt;

  assign cmp_mask_first = mask;
  assign cmp_mask       = mask_q;
`else
  assign cmp_mask_first = FULL_MASK;
  assign cmp_mask       = FULL_MASK;
`endif

  // The first beat of a window compares against the live inputs because the
  // reference registers are only loaded on that same edge.
  assign match_first = beat_match(seq, num, cmp_mask_first);
  assign match_q     = beat_match(seq, num_q, cmp_mask);
  assign inc_res     = sat_inc(cnt_q, match_q);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      hit_q   <= 1'b0;
      sat_q   <= 1'b0;
      num_q   <= '0;
`ifdef MATCH_BURST_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      hit_q   <= hit_nxt;
      sat_q   <= sat_nxt;
      num_q   <= num_nxt;
`ifdef MATCH_BURST_MASK_EN
      mask_q  <= mask_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid)
          state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        // Window close: only enter HIT if there is something to emit.
        if (!valid)
          state_nxt = (cnt_q != CNT_ZERO) ? ST_HIT : ST_IDLE;
      end
      ST_HIT: begin
        // Leave on the last burst cycle; cnt==0 here is only a safety net.
        if (cnt_q <= CNT_ONE)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered-output / datapath next values and combinational ready
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_nxt  = cnt_q;
    hit_nxt  = hit_q;
    sat_nxt  = sat_q;
    num_nxt  = num_q;
`ifdef MATCH_BURST_MASK_EN
    mask_nxt = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        hit_nxt = 1'b0;
        if (valid) begin
          num_nxt  = num;
`ifdef MATCH_BURST_MASK_EN
          mask_nxt = mask;
`endif
          cnt_nxt  = match_first ? CNT_ONE : CNT_ZERO;
          sat_nxt  = 1'b0;
        end
      end
      ST_COUNT: begin
        if (valid) begin
          cnt_nxt = inc_res[CNT_W-1:0];
          if (inc_res[CNT_W])
            sat_nxt = 1'b1;
        end else begin
          hit_nxt = (cnt_q != CNT_ZERO);
        end
      end
      ST_HIT: begin
        // Beats are neither counted nor queued while the burst drains.
        if (cnt_q != CNT_ZERO)
          cnt_nxt = cnt_q - CNT_ONE;
        hit_nxt = (cnt_q > CNT_ONE);
      end
      default: begin
        cnt_nxt  = CNT_ZERO;
        hit_nxt  = 1'b0;
        sat_nxt  = 1'b0;
        num_nxt  = '0;
`ifdef MATCH_BURST_MASK_EN
        mask_nxt = '0;
`endif
      end
    endcase
  end

  always_comb begin
    ready = (state_q != ST_HIT);
  end

  assign hit   = hit_q;
  assign cnt   = cnt_q;
  assign sat   = sat_q;
  assign state = state_q;

endmodule

// File: tb/tb_match_burst_fsm.sv
module tb_match_burst_fsm;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_HIT   = 2'b10;

  logic              clock;
  logic              reset;
  logic              valid;
  logic [DATA_W-1:0] num;
  logic [DATA_W-1:0] seq;
`ifdef MATCH_BURST_MASK_EN
  logic [DATA_W-1:0] mask;
`endif
  logic              ready;
  logic              hit;
  logic [CNT_W-1:0]  cnt;
  logic              sat;
  logic [1:0]        state;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  match_burst_fsm #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .valid (valid),
    .num   (num),
    .seq   (seq),
`ifdef MATCH_BURST_MASK_EN
    .mask  (mask),
`endif
    .ready (ready),
    .hit   (hit),
    .cnt   (cnt),
    .sat   (sat),
    .state (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    num   = 4'd0;
    seq   = 4'd0;
`ifdef MATCH_BURST_MASK_EN
    mask  = 4'hF;
`endif

    // Reset state
    tick();
    chk("rst_state", state, S_IDLE);
    chk("rst_cnt",   cnt,   0);
    chk("rst_hit",   hit,   0);
    chk("rst_sat",   sat,   0);
    chk("rst_ready", ready, 1);
    reset = 1'b1;
    tick();
    chk("idle_hold", state, S_IDLE);

    // 1: ten non-matching beats
    num = 4'd5; seq = 4'hA; valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_nohit", hit, 0);
    end
    chk("t1_cnt",   cnt,   0);
    chk("t1_state", state, S_COUNT);
    valid = 1'b0;
    tick();
    chk("t1_idle", state, S_IDLE);
    chk("t1_hit",  hit,   0);

    // 2: ten matching beats, burst of ten
    num = 4'd5; seq = 4'd5; valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_cnt", cnt, 10);
    valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hit",   hit,   1);
      chk("t2_ready", ready, 0);
      chk("t2_state", state, S_HIT);
    end
    tick();
    chk("t2_hit_end", hit,   0);
    chk("t2_idle",    state, S_IDLE);
    chk("t2_cnt0",    cnt,   0);

    // 3a: length-1 window with a match
    seq = 4'd5; valid = 1'b1;
    tick();
    chk("t3a_cnt", cnt, 1);
    valid = 1'b0;
    tick();
    chk("t3a_hit", hit, 1);
    tick();
    chk("t3a_hit_end", hit,   0);
    chk("t3a_idle",    state, S_IDLE);

    // 3b: length-1 window without a match
    seq = 4'd3; valid = 1'b1;
    tick();
    chk("t3b_cnt", cnt, 0);
    valid = 1'b0;
    tick();
    chk("t3b_idle", state, S_IDLE);
    chk("t3b_hit",  hit,   0);

    // 4: saturation after twenty matching beats
    seq = 4'd5; valid = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("t4_cnt15_nosat", sat, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t4_cnt", cnt, 15);
    chk("t4_sat", sat, 1);
    valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_hit", hit, 1);
    end
    tick();
    chk("t4_hit_end",  hit,   0);
    chk("t4_idle",     state, S_IDLE);
    chk("t4_sat_held", sat,   1);

    // 5: valid held through HIT, zero-bubble restart
    seq = 4'd5; valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_cnt3",      cnt, 3);
    chk("t5_sat_clear", sat, 0);
    valid = 1'b0;
    tick();
    chk("t5_hit_start", hit, 1);
    valid = 1'b1;
    tick();
    chk("t5_ignored_cnt2", cnt,   2);
    chk("t5_ready0",       ready, 0);
    tick();
    chk("t5_ignored_cnt1", cnt, 1);
    tick();
    chk("t5_idle",   state, S_IDLE);
    chk("t5_cnt0",   cnt,   0);
    chk("t5_ready1", ready, 1);
    num = 4'd9; seq = 4'd9;
    tick();
    chk("t5_restart_state", state, S_COUNT);
    chk("t5_restart_cnt",   cnt,   1);
    num = 4'd2;                       // reference is latched; num changes ignored
    tick();
    chk("t5_cnt2", cnt, 2);
    seq = 4'd0;
    tick();
    chk("t5_nomatch", cnt, 2);
    valid = 1'b0;
    tick();
    chk("t5_hit_a", hit, 1);
    tick();
    chk("t5_hit_b", hit, 1);
    tick();
    chk("t5_hit_c", hit, 0);

    // 6: reset in the middle of a burst
    num = 4'd5; seq = 4'd5; valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    valid = 1'b0;
    tick();
    chk("t6_pre_cnt", cnt, 6);
    chk("t6_pre_hit", hit, 1);
    reset = 1'b0;
    tick();
    chk("t6_hit",   hit,   0);
    chk("t6_cnt",   cnt,   0);
    chk("t6_state", state, S_IDLE);
    chk("t6_ready", ready, 1);
    reset = 1'b1;
    tick();

`ifdef MATCH_BURST_MASK_EN
    // Masked compare: only the two LSBs participate
    mask = 4'b0011; num = 4'd5; seq = 4'b1101; valid = 1'b1;
    tick();
    chk("mask_first_match", cnt, 1);
    mask = 4'hF; num = 4'd0;          // latched copies keep the old compare
    seq = 4'b0001;
    tick();
    chk("mask_match2", cnt, 2);
    seq = 4'b0110;
    tick();
    chk("mask_nomatch", cnt, 2);
    valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mask_idle", state, S_IDLE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
